// File: rtl/uart_tx_streamer.sv
// -----------------------------------------------------------------------------
// uart_tx_streamer
//
// Byte-stream front end for the UART peripheral. Bytes from a producer are
// buffered in a small FIFO and each byte is drained through a fixed sequence
// of local-bus register accesses:
//   TXDATA <= byte, CTRL <= strtx=1, poll STAT until tbusy=1,
//   CTRL <= strtx=0, poll STAT until tbusy=0.
// Software therefore never has to poll tbusy itself.
//
// Handshake semantics (both bus directions and the producer port):
//   A request (wen / ren) is raised together with its address and data and is
//   held, unchanged, until the matching acknowledge (wready / rvalid) is
//   sampled high on a rising clock edge. The request is low in the following
//   cycle. wen and ren are never high together. A producer byte is taken on
//   every rising edge where s_valid and s_ready are both high.
//
// Optional feature (macro UART_STREAM_TIMEOUT_EN):
//   A 20-bit counter bounds each STAT polling phase. When it saturates at
//   20'hFFFFF the phase ends after the outstanding read completes, and the
//   sticky output timeout_err is set. Without the macro polling is unbounded
//   and the timeout_err port does not exist.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   s_data/s_valid   producer byte stream, s_ready = FIFO not full (registered)
//   waddr/wdata/wen  bus write request, wstrb always all-ones, wready accept
//   raddr/ren        bus read request, rdata/rvalid read response
//   fifo_level       FIFO occupancy
//   idle             FIFO empty and FSM in IDLE
//   timeout_err      sticky polling timeout flag (macro builds only)
//   state_dbg        current FSM state encoding
// -----------------------------------------------------------------------------
module uart_tx_streamer #(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              STRB_W      = DATA_W / 8,
  parameter int              FIFO_DEPTH  = 16,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = 32'h0,
  parameter logic [ADDR_W-1:0] STAT_ADDR   = 32'h4,
  parameter logic [ADDR_W-1:0] TXDATA_ADDR = 32'h8,
  parameter logic [3:0]      BR_SEL      = 4'd0,
  parameter logic [7:0]      CLK_CFG     = 8'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [ADDR_W-1:0]             waddr,
  output logic [DATA_W-1:0]             wdata,
  output logic                          wen,
  output logic [STRB_W-1:0]             wstrb,
  input  logic                          wready,
  output logic [ADDR_W-1:0]             raddr,
  output logic                          ren,
  input  logic [DATA_W-1:0]             rdata,
  input  logic                          rvalid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          idle,
`ifdef UART_STREAM_TIMEOUT_EN
  output logic                          timeout_err,
`endif
  output logic [2:0]                    state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // CTRL: en=1, strtx in bit1, br in [5:2], clk in [13:6], all else zero.
  localparam logic [DATA_W-1:0] CTRL_IDLE  = DATA_W'({CLK_CFG, BR_SEL, 1'b0, 1'b1});
  localparam logic [DATA_W-1:0] CTRL_START = DATA_W'({CLK_CFG, BR_SEL, 1'b1, 1'b1});

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_DATA  = 3'd1,
    S_WR_START = 3'd2,
    S_RD_BUSY1 = 3'd3,
    S_WR_CLR   = 3'd4,
    S_RD_BUSY0 = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             s_ready_q, s_ready_d;
  logic             push, pop;

  state_t state_q, state_d;

  assign push = s_valid && s_ready_q;
  // Pop decision uses the registered count, so a push into an empty FIFO is
  // not visible to the FSM until the next cycle.
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
    s_ready_d = (count_d != LVL_W'(FIFO_DEPTH));
  end

  // Storage carries no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Polling timeout (optional)
  // ---------------------------------------------------------------------------
  logic tmo_hit;
  logic in_poll_d;

  assign in_poll_d = (state_d == S_RD_BUSY1) || (state_d == S_RD_BUSY0);

`ifdef UART_STREAM_TIMEOUT_EN
  logic [19:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  assign tmo_hit = (tmo_cnt_q == 20'hFFFFF);

  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    if (in_poll_d && (state_d != state_q)) begin
      tmo_cnt_d = '0;
    end else if (in_poll_d && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 20'd1;
    end
    if (tmo_hit && (state_q == S_RD_BUSY1 || state_q == S_RD_BUSY0)) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_in_poll;
  assign tmo_hit        = 1'b0;
  assign unused_in_poll = in_poll_d;
`endif

  // ---------------------------------------------------------------------------
  // Bus sequencing FSM
  // ---------------------------------------------------------------------------
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              idle_q, idle_d;
  logic              ack_w, ack_r, tbusy;
  logic              unused_rdata;

  assign ack_w        = wen_q && wready;
  assign ack_r        = ren_q && rvalid;
  assign tbusy        = rdata[0];
  assign unused_rdata = ^rdata[DATA_W-1:1];

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    case (state_q)
      S_IDLE: begin
        // The popped byte is captured straight into the write-data register.
        if (pop) begin
          state_d = S_WR_DATA;
          wen_d   = 1'b1;
          waddr_d = TXDATA_ADDR;
          wdata_d = DATA_W'(mem_q[rd_ptr_q]);
        end
      end
      S_WR_DATA: begin
        if (ack_w) begin
          wen_d   = 1'b0;
          state_d = S_WR_START;
        end
      end
      S_WR_START: begin
        if (!wen_q) begin
          wen_d   = 1'b1;
          waddr_d = CTRL_ADDR;
          wdata_d = CTRL_START;
        end else if (ack_w) begin
          wen_d   = 1'b0;
          state_d = S_RD_BUSY1;
        end
      end
      S_RD_BUSY1: begin
        // Wait for the transmitter to report busy, i.e. it took the byte.
        if (!ren_q) begin
          if (tmo_hit) begin
            state_d = S_WR_CLR;
          end else begin
            ren_d   = 1'b1;
            raddr_d = STAT_ADDR;
          end
        end else if (ack_r) begin
          ren_d = 1'b0;
          if (tbusy || tmo_hit) state_d = S_WR_CLR;
        end
      end
      S_WR_CLR: begin
        if (!wen_q) begin
          wen_d   = 1'b1;
          waddr_d = CTRL_ADDR;
          wdata_d = CTRL_IDLE;
        end else if (ack_w) begin
          wen_d   = 1'b0;
          state_d = S_RD_BUSY0;
        end
      end
      S_RD_BUSY0: begin
        // Wait for the frame to finish before the next byte is started.
        if (!ren_q) begin
          if (tmo_hit) begin
            state_d = S_IDLE;
          end else begin
            ren_d   = 1'b1;
            raddr_d = STAT_ADDR;
          end
        end else if (ack_r) begin
          ren_d = 1'b0;
          if (!tbusy || tmo_hit) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
    endcase
    idle_d = (count_d == '0) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      idle_q  <= idle_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign wen        = wen_q;
  assign wstrb      = '1;
  assign raddr      = raddr_q;
  assign ren        = ren_q;
  assign fifo_level = count_q;
  assign idle       = idle_q;
  assign state_dbg  = state_q;

endmodule
